k_sorting_p2: RTL
=================

# k_sorting_p2

Phase-2 merge/drain for the KNN accelerator. It is the consumer end of the phase-1 sorter output port. After the distance stream ends, it drives `done`/`outEn` into NUM_CH phase-1 sorters and reads their sorted heads (`dataNameOut`/`dataValueOut`). It merges them into the global K nearest, ascending by value, and emits those K results on a valid/ready stream toward the AXI result FIFO.

## Interface
Parameters:
- `VAL_WIDTH`, 32: distance value width; matches phase 1.
- `NUM_CH`, 1: number of phase-1 sorter channels.
- `K`, 1: results per channel and total results emitted.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  last distance delivered to all channels; begins the merge.
- `chDone`  out  1  to every phase-1 `done` input.
- `chOutEn`  out  NUM_CH  one-hot pop pulse, one per phase-1 `outEn`.
- `chNameIn`  in  NUM_CH*32  channel c head name at bits [32c+31:32c].
- `chValueIn`  in  NUM_CH*VAL_WIDTH  channel c head value, packed the same way.
- `outValid`  out  1  result valid.
- `outReady`  in  1  downstream accept.
- `outName`  out  32  result entry ID.
- `outValue`  out  VAL_WIDTH  result distance.
- `outLast`  out  1  set with the K-th result.
- `finished`  out  1  all K results accepted.

## Operation
- States: IDLE, SELECT, HOLD, DONE.
- IDLE
  - `start`=1 → SELECT.
  - `chDone` is registered; it goes to 1 on entry to SELECT and stays 1 until reset.
- SELECT (one cycle)
  - Candidate channels are those with `used[c]` < K.
  - Winner is the candidate with the smallest `chValueIn`; a tie goes to the lowest channel index.
  - All-ones sentinel values are ordinary candidates; they are not filtered.
  - At the clock edge, register:
    - the winner's name and value into `outName`/`outValue`;
    - `outValid`=1;
    - `outLast`=(`emitted`==K-1);
    - `chOutEn`=onehot(winner);
    - `used[winner]`+1 and `emitted`+1.
  - → HOLD.
- HOLD
  - `chOutEn` returns to 0 after its single cycle.
  - `outName`, `outValue` and `outLast` hold stable while `outValid`=1 and `outReady`=0.
  - On `outValid`&`outReady`, clear `outValid`. Then go to DONE if `outLast` was set, otherwise to SELECT.
- DONE
  - `finished`=1 and `chDone`=1.
  - `start` is ignored. The block leaves DONE only on `reset`, because phase-1 pointers clear only on reset.
- `start` is ignored in every state except IDLE.
- Counters and widths:
  - `used[c]` and `emitted` are $clog2(K+1) bits and saturate at K.
  - `used[c]`==K excludes channel c. This covers phase 1's pointer saturating at K-1.
  - NUM_CH≥1 guarantees at least one candidate exists in every SELECT.
- Comparison is unsigned on VAL_WIDTH bits. The name is passed through unmodified.

## Timing
- All outputs are registered.
- Reset values:
  - `chOutEn`=0, `chDone`=0, `outValid`=0, `outLast`=0, `finished`=0.
  - `outName`=0, `outValue`=0.
  - State IDLE; all counters 0.
- `start` high in cycle n:
  - SELECT in cycle n+1;
  - `outValid` and `chOutEn` high in n+2;
  - the phase-1 head is updated and visible in n+3.
- Peak throughput is one result per 2 cycles (SELECT+HOLD) with `outReady` held at 1.
- Reset asserted in any state returns everything to reset values on the next edge. No partial result is emitted afterwards.

## Structure
- Shared package `knn_pkg`: `VAL_WIDTH` default, name width constant 32, state encoding.
- One sub-module `k_min_select`: combinational NUM_CH-way arg-min with valid mask, returning winner index and value, lowest index wins ties.

## Test plan
- NUM_CH=2, K=3. ch0={1,4,9}/names{0,2,4}, ch1={2,3,10}/names{1,3,5}, `outReady`=1 → outputs (0,1),(1,2),(3,3); `outLast` on the 3rd; `finished`; `chOutEn` pattern 01,10,10.
- Ties: ch0={5,5,5}, ch1={5,5,5} → all three from ch0; ch1 never pulsed.
- Backpressure: `outReady`=0 for 4 cycles on the 1st result → outputs stable; `chOutEn` pulses exactly once; no second SELECT until accept.
- Sentinel/exhaustion: NUM_CH=1, K=3, head stays at 0xFFFFFFFF after 1 real entry → emits {real, 0xFFFFFFFF, 0xFFFFFFFF}; `used`=3; no extra pop.
- Reset mid-HOLD with `outValid`=1 → next cycle all outputs 0, state IDLE. A subsequent `start` gives a correct full merge.
- `start` pulsed in HOLD and in DONE → no effect; result count stays K.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared definitions for the KNN accelerator phase-2 merge logic.
package knn_pkg;

    localparam int VAL_WIDTH_DEF = 32;
    localparam int NAME_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/k_min_select.sv
// Combinational NUM_CH-way arg-min over the masked channel heads.
// Ties resolve to the lowest channel index.
module k_min_select #(
    parameter int NUM_CH    = 1,
    parameter int VAL_WIDTH = 32,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_CH*VAL_WIDTH-1:0] i_values,
    input  logic [NUM_CH-1:0]           i_valid,
    output logic [IDX_W-1:0]            o_winIdx,
    output logic [VAL_WIDTH-1:0]        o_winValue
);

    logic w_found;

    // Scan channels in ascending order; a strict less-than keeps the earlier index on ties.
    always_comb begin
        w_found    = 1'b0;
        o_winIdx   = '0;
        o_winValue = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_valid[c] && (!w_found || (i_values[c*VAL_WIDTH +: VAL_WIDTH] < o_winValue))) begin
                w_found    = 1'b1;
                o_winIdx   = IDX_W'(c);
                o_winValue = i_values[c*VAL_WIDTH +: VAL_WIDTH];
            end
        end
    end

endmodule

// File: rtl/k_sorting_p2.sv
// Phase-2 merge/drain: pops the phase-1 sorter heads one at a time and
// emits the global K nearest, ascending by value, on a valid/ready stream.
module k_sorting_p2
    import knn_pkg::*;
#(
    parameter int VAL_WIDTH = VAL_WIDTH_DEF,
    parameter int NUM_CH    = 1,
    parameter int K         = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        chDone,
    output logic [NUM_CH-1:0]           chOutEn,
    input  logic [NUM_CH*NAME_WIDTH-1:0] chNameIn,
    input  logic [NUM_CH*VAL_WIDTH-1:0] chValueIn,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [NAME_WIDTH-1:0]       outName,
    output logic [VAL_WIDTH-1:0]        outValue,
    output logic                        outLast,
    output logic                        finished
);

    localparam int CW    = $clog2(K + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t r_state;
    state_t w_nextState;

    logic [CW-1:0]         r_used [NUM_CH];
    logic [CW-1:0]         r_emitted;
    logic                  r_chDone;
    logic [NUM_CH-1:0]     r_chOutEn;
    logic                  r_outValid;
    logic [NAME_WIDTH-1:0] r_outName;
    logic [VAL_WIDTH-1:0]  r_outValue;
    logic                  r_outLast;
    logic                  r_finished;

    logic [NUM_CH-1:0]     w_cand;
    logic [IDX_W-1:0]      w_winIdx;
    logic [VAL_WIDTH-1:0]  w_winValue;
    logic [NAME_WIDTH-1:0] w_winName;
    logic [NUM_CH-1:0]     w_winOneHot;

    // A channel that has already supplied K entries is no longer a candidate.
    always_comb begin
        w_cand = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_cand[c] = (r_used[c] < CW'(K));
        end
    end

    k_min_select #(
        .NUM_CH    (NUM_CH),
        .VAL_WIDTH (VAL_WIDTH),
        .IDX_W     (IDX_W)
    ) u_minSelect (
        .i_values   (chValueIn),
        .i_valid    (w_cand),
        .o_winIdx   (w_winIdx),
        .o_winValue (w_winValue)
    );

    // Expand the winner index into a one-hot pop mask and pick its name.
    always_comb begin
        w_winOneHot = '0;
        w_winName   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (IDX_W'(c) == w_winIdx) begin
                w_winOneHot[c] = 1'b1;
                w_winName      = chNameIn[c*NAME_WIDTH +: NAME_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; DONE is only left through reset since phase-1 pointers clear only then.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = SELECT;
            SELECT:  w_nextState = HOLD;
            HOLD:    if (r_outValid && outReady) w_nextState = r_outLast ? DONE : SELECT;
            DONE:    w_nextState = DONE;
            default: w_nextState = IDLE;
        endcase
    end

    // Registered datapath: capture the winner in SELECT, hold it until accepted in HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_emitted  <= '0;
            r_chDone   <= 1'b0;
            r_chOutEn  <= '0;
            r_outValid <= 1'b0;
            r_outName  <= '0;
            r_outValue <= '0;
            r_outLast  <= 1'b0;
            r_finished <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_used[c] <= '0;
            end
        end else begin
            r_chOutEn <= '0;
            case (r_state)
                IDLE: begin
                    if (start) r_chDone <= 1'b1;
                end
                SELECT: begin
                    r_outName  <= w_winName;
                    r_outValue <= w_winValue;
                    r_outValid <= 1'b1;
                    r_outLast  <= (r_emitted == CW'(K - 1));
                    r_chOutEn  <= w_winOneHot;
                    if (r_emitted != CW'(K)) r_emitted <= r_emitted + 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (w_winOneHot[c] && (r_used[c] != CW'(K))) begin
                            r_used[c] <= r_used[c] + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_outValid && outReady) begin
                        r_outValid <= 1'b0;
                        if (r_outLast) r_finished <= 1'b1;
                    end
                end
                DONE: begin
                    r_finished <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign chDone   = r_chDone;
    assign chOutEn  = r_chOutEn;
    assign outValid = r_outValid;
    assign outName  = r_outName;
    assign outValue = r_outValue;
    assign outLast  = r_outLast;
    assign finished = r_finished;

endmodule
